// File: rtl/cla_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla_pkg                                                   |
// | Brief    : Shared constants and carry-lookahead helper for the       |
// |            shared 5-bit adder slice and its arbiter wrapper.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cla_pkg;

  // Operand width of the shared adder slice
  localparam int CLA_W     = 5;
  // Result payload width: sum bits plus carry-out
  localparam int CLA_RES_W = CLA_W + 1;

  // Packed width of one result entry {id, sum, cout} for a given ID width
  function automatic int cla_entry_w(input int idw);
    return idw + CLA_RES_W;
  endfunction

  // Carry-lookahead carries with zero carry-in.
  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ...  (fully expanded, no ripple)
  function automatic logic [CLA_W:0] cla_carries(input logic [CLA_W-1:0] p,
                                                 input logic [CLA_W-1:0] g);
    logic [CLA_W:0] c;
    logic           term;
    c = '0;
    for (int i = 0; i < CLA_W; i++) begin
      c[i+1] = g[i];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla_adder                                                 |
// | Brief    : Two-stage pipelined 5-bit carry-lookahead adder. Stage 1  |
// |            registers the operands, stage 2 registers sum/carry-out.  |
// |            Data registers carry no reset.                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cla_adder
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  output logic [CLA_W-1:0] sum,
  output logic             cout
);

  logic [CLA_W-1:0] a_q, b_q;
  logic [CLA_W-1:0] a_d, b_d;
  logic [CLA_W-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [CLA_W-1:0] p, g;
  logic [CLA_W:0]   c;

  // Next-state for both pipeline stages: capture operands, then add them
  always_comb begin
    a_d    = a;
    b_d    = b;
    p      = a_q ^ b_q;
    g      = a_q & b_q;
    c      = cla_carries(p, g);
    sum_d  = p ^ c[CLA_W-1:0];
    cout_d = c[CLA_W];
  end

  // Free-running data registers; validity is tracked by the owner of this slice
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sum_q  <= sum_d;
    cout_q <= cout_d;
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: rtl/cla_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla_rsp_fifo                                              |
// | Brief    : Circular-buffer response FIFO with async-reset pointers   |
// |            and occupancy count. Head is read combinationally.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cla_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  // Pointer wrap at DEPTH (DEPTH need not be a power of two); count tracks push/pop
  always_comb begin
    do_pop   = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state: cleared asynchronously so stale entries vanish on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: written on push only, never reset (count gates visibility)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/cla_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla_add_arbiter                                           |
// | Brief    : Round-robin shares one pipelined CLA adder among NREQ     |
// |            requesters; a tag pipeline follows each result into a     |
// |            credit-protected response FIFO.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cla_add_arbiter
  import cla_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*CLA_W-1:0]   req_a,
  input  logic [NREQ*CLA_W-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [CLA_W-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    busy
);

  localparam int ENTRY_W = cla_entry_w(IDW);
  localparam int CW      = $clog2(DEPTH+1);
  localparam int OW      = CW + 1;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic [IDW-1:0]     id1_q, id1_d, id2_q, id2_d;

  logic [CW-1:0]      fifo_count;
  logic [OW-1:0]      occ;
  logic               credit_ok;
  logic [NREQ-1:0]    gnt_oh;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic [IDW-1:0]     cand;
  logic [CLA_W-1:0]   a_mux, b_mux;
  logic [CLA_W-1:0]   add_sum;
  logic               add_cout;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  // Conservative credit: in-flight results count against FIFO space, pops are not credited
  always_comb begin
    occ       = OW'(fifo_count) + OW'(v1_q) + OW'(v2_q);
    credit_ok = (occ < OW'(DEPTH));
  end

  // Round-robin search from the pointer; held off entirely during reset
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (credit_ok && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IDW'((int'(ptr_q) + k) % NREQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any      = 1'b1;
          gnt_idx      = cand;
          gnt_oh[cand] = 1'b1;
        end
      end
    end
  end

  // One-hot AND-OR operand mux into the adder input stage
  always_comb begin
    a_mux = '0;
    b_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        a_mux = req_a[i*CLA_W +: CLA_W];
        b_mux = req_b[i*CLA_W +: CLA_W];
      end
    end
  end

  // Pointer advance past the winner, and tag pipeline shadowing the adder stages
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
    v1_d  = gnt_any;
    id1_d = gnt_idx;
    v2_d  = v1_q;
    id2_d = id1_q;
  end

  // Arbitration and tag state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      id1_q <= '0;
      id2_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      id1_q <= id1_d;
      id2_q <= id2_d;
    end
  end

  cla_adder u_adder (
    .clk  (clk),
    .a    (a_mux),
    .b    (b_mux),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign push_entry = {id2_q, add_sum, add_cout};

  cla_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (v2_q),
    .push_data (push_entry),
    .pop       (rsp_valid & rsp_ready),
    .out_valid (rsp_valid),
    .out_data  (head_entry),
    .count     (fifo_count)
  );

  assign req_ready = gnt_oh;
  assign rsp_id    = head_entry[ENTRY_W-1 -: IDW];
  assign rsp_sum   = head_entry[CLA_W:1];
  assign rsp_cout  = head_entry[0];
  assign busy      = v1_q | v2_q | (fifo_count != '0);

endmodule
`default_nettype wire
